// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared state encoding and default timing constants for the
// key event decoder. The KEY_EVT_REPEAT_EN macro (used by key_event_decoder)
// selects whether auto-repeat is built.
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PRESS1 = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4,
        ST_HOLD   = 3'd5
    } key_state_e;

    // 100 MHz clock
    localparam int LONG_CYC_100M   = 2_000_000;
    localparam int DOUBLE_CYC_100M = 1_000_000;
    localparam int REPEAT_CYC_100M = 500_000;

    // 25 MHz clock
    localparam int LONG_CYC_25M    = 500_000;
    localparam int DOUBLE_CYC_25M  = 250_000;
    localparam int REPEAT_CYC_25M  = 125_000;

    // 1 MHz clock
    localparam int LONG_CYC_1M     = 20_000;
    localparam int DOUBLE_CYC_1M   = 10_000;
    localparam int REPEAT_CYC_1M   = 5_000;

endpackage

// File: rtl/key_evt_timer.sv
// key_evt_timer: free-running up-counter with synchronous clear (priority)
// and increment enable.
module key_evt_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced key level into one-cycle short press,
// long press, double click and (with KEY_EVT_REPEAT_EN defined) auto-repeat
// pulses. Without KEY_EVT_REPEAT_EN, repeat_pulse is tied low.
//
// state  | meaning
// ARM    | after reset; wait for a release before decoding anything
// IDLE   | released, no sequence in progress
// PRESS1 | first press held, timing toward long press
// GAP    | released after first click, waiting for a second press
// PRESS2 | second press held
// HOLD   | long press reached, waiting for release
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter logic ACTIVE_LEVEL = 1'b1,
    parameter int   LONG_CYC     = 2_000_000,
    parameter int   DOUBLE_CYC   = 1_000_000,
    parameter int   REPEAT_CYC   = 500_000,
    parameter int   CNT_W        = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYC - 1);
`ifdef KEY_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

    key_state_e       state_q, state_d;
    logic             key_q;
    // key_q holds its reset value for one cycle after reset, so ARM must not
    // trust it until the real level has been captured once.
    logic             settle_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             repeat_q, repeat_d;
    logic             rep_hit;
    logic             timer_clr;
    logic             timer_inc;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    assign pressed = (key_q == ACTIVE_LEVEL);

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .inc (timer_inc),
        .cnt (cnt)
    );

    // Next-state, pulse and counter-control decode.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        repeat_d = 1'b0;
        rep_hit  = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (!pressed && !settle_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pressed) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!pressed) begin
                    state_d = ST_GAP;
                end else if (cnt == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (pressed) begin
                    state_d = ST_PRESS2;
                end else if (cnt == DOUBLE_LAST) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (!pressed) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt == LONG_LAST) begin
                    short_d = 1'b1;
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                end
`ifdef KEY_EVT_REPEAT_EN
                else if (cnt == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    rep_hit  = 1'b1;
                end
`endif
            end
            default: state_d = ST_ARM;
        endcase
        timer_clr = (state_d != state_q) || (state_d == ST_ARM) ||
                    (state_d == ST_IDLE) || rep_hit;
        timer_inc = !timer_clr;
    end

    // State, input capture and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARM;
            key_q    <= ~ACTIVE_LEVEL;
            settle_q <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_level;
            settle_q <= 1'b0;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            repeat_q <= repeat_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = double_q;
    assign repeat_pulse = repeat_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters.
// Expectations for repeat_pulse follow KEY_EVT_REPEAT_EN as compiled.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_level = 1'b0;
    logic short_press, long_press, double_click, repeat_pulse, busy;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int excl_err = 0;
    int q_short[$];
    int q_long[$];
    int q_double[$];
    int q_rep[$];

    key_event_decoder #(
        .ACTIVE_LEVEL (1'b1),
        .LONG_CYC     (20),
        .DOUBLE_CYC   (10),
        .REPEAT_CYC   (8),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_level    (key_level),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge number after which each pulse was seen high.
    always @(negedge clk) begin
        if (short_press)  q_short.push_back(cyc);
        if (long_press)   q_long.push_back(cyc);
        if (double_click) q_double.push_back(cyc);
        if (repeat_pulse) q_rep.push_back(cyc);
        if ((int'(short_press) + int'(double_click) + int'(repeat_pulse)) > 1)
            excl_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        q_short.delete();
        q_long.delete();
        q_double.delete();
        q_rep.delete();
    endtask

    initial begin
        int c0;
        int c1;

        // Reset state
        tick(3);
        check("rst_short",  int'(short_press), 0);
        check("rst_long",   int'(long_press), 0);
        check("rst_double", int'(double_click), 0);
        check("rst_repeat", int'(repeat_pulse), 0);
        check("rst_busy",   int'(busy), 1);
        rst = 1'b0;
        tick(4);
        check("armed_idle_busy", int'(busy), 0);
        clear_logs();

        // Single click: press 5, release
        key_level = 1'b1;
        tick(5);
        key_level = 1'b0;
        c1 = cyc;
        tick(20);
        check("single_short_n",  q_short.size(), 1);
        check("single_short_t",  qat(q_short, 0), c1 + 12);
        check("single_long_n",   q_long.size(), 0);
        check("single_double_n", q_double.size(), 0);
        check("single_rep_n",    q_rep.size(), 0);
        check("single_busy",     int'(busy), 0);
        clear_logs();

        // Long press held 42 cycles
        key_level = 1'b1;
        c0 = cyc;
        tick(42);
        key_level = 1'b0;
        tick(10);
        check("long_long_n",  q_long.size(), 1);
        check("long_long_t",  qat(q_long, 0), c0 + 22);
        check("long_short_n", q_short.size(), 0);
        check("long_double_n", q_double.size(), 0);
`ifdef KEY_EVT_REPEAT_EN
        check("long_rep_n",  q_rep.size(), 2);
        check("long_rep0_t", qat(q_rep, 0), c0 + 30);
        check("long_rep1_t", qat(q_rep, 1), c0 + 38);
`else
        check("long_rep_n",  q_rep.size(), 0);
`endif
        check("long_busy", int'(busy), 0);
        clear_logs();

        // Double click: press 4, release 5, press 4, release
        key_level = 1'b1;
        tick(4);
        key_level = 1'b0;
        tick(5);
        key_level = 1'b1;
        tick(4);
        key_level = 1'b0;
        c1 = cyc;
        tick(20);
        check("dbl_double_n", q_double.size(), 1);
        check("dbl_double_t", qat(q_double, 0), c1 + 2);
        check("dbl_short_n",  q_short.size(), 0);
        check("dbl_long_n",   q_long.size(), 0);
        check("dbl_rep_n",    q_rep.size(), 0);
        clear_logs();

        // Held second click: press 4, release 3, hold 28
        key_level = 1'b1;
        tick(4);
        key_level = 1'b0;
        tick(3);
        key_level = 1'b1;
        c0 = cyc;
        tick(28);
        key_level = 1'b0;
        tick(20);
        check("held2_short_n",  q_short.size(), 1);
        check("held2_short_t",  qat(q_short, 0), c0 + 22);
        check("held2_long_n",   q_long.size(), 1);
        check("held2_long_t",   qat(q_long, 0), c0 + 22);
        check("held2_double_n", q_double.size(), 0);
        check("held2_rep_n",    q_rep.size(), 0);
        clear_logs();

        // Reset while held in PRESS1, key kept down 40 cycles in total
        key_level = 1'b1;
        c0 = cyc;
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 34; i++) begin
            tick(1);
            check($sformatf("rsthold_busy_%0d", cyc - c0), int'(busy), 1);
        end
        key_level = 1'b0;
        tick(1);
        check("rsthold_busy_rel", int'(busy), 1);
        tick(5);
        check("rsthold_idle",     int'(busy), 0);
        check("rsthold_short_n",  q_short.size(), 0);
        check("rsthold_long_n",   q_long.size(), 0);
        check("rsthold_double_n", q_double.size(), 0);
        check("rsthold_rep_n",    q_rep.size(), 0);
        clear_logs();

        // Normal click after the aborted sequence
        key_level = 1'b1;
        tick(3);
        key_level = 1'b0;
        c1 = cyc;
        tick(20);
        check("post_rst_short_n", q_short.size(), 1);
        check("post_rst_short_t", qat(q_short, 0), c1 + 12);
        check("post_rst_long_n",  q_long.size(), 0);

        check("exclusive_pulses", excl_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
